// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one RAM between an icache and a dcache, with a
// starvation limit that forces an instruction grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIgnt = 2'd1,
    StDgnt = 2'd2
  } state_e;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [2:0] dstreak_q, dstreak_d;
  logic       dreq;
  logic       i_act, d_act, i_done, d_done;

  assign dreq = dREN | dWEN;

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    case (state_q)
      StIdle: begin
        if (iREN && (dstreak_q == StarveMax)) begin
          state_d   = StIgnt;
          dstreak_d = '0;
        end else if (dreq) begin
          state_d   = StDgnt;
          dstreak_d = iREN ? dstreak_q + 3'd1 : '0;
        end else if (iREN) begin
          state_d   = StIgnt;
          dstreak_d = '0;
        end else begin
          dstreak_d = '0;
        end
      end
      StIgnt: begin
        if (!iREN || (ramstate == RamAccess)) state_d = StIdle;
      end
      StDgnt: begin
        if (!dreq || (ramstate == RamAccess)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  // A grant only drives the RAM while its owner still requests; a dropped request aborts.
  assign i_act  = !RST && (state_q == StIgnt) && iREN;
  assign d_act  = !RST && (state_q == StDgnt) && dreq;
  assign i_done = i_act && (ramstate == RamAccess);
  assign d_done = d_act && (ramstate == RamAccess);

  always_comb begin
    ramREN   = i_act | (d_act & ~dWEN);
    ramWEN   = d_act & dWEN;
    ramaddr  = '0;
    ramstore = '0;
    if (i_act) begin
      ramaddr = iaddr;
    end else if (d_act) begin
      ramaddr  = daddr;
      ramstore = dstore;
    end
    iwait = ~i_done;
    dwait = ~d_done;
    iload = i_done ? ramload : '0;
    dload = (d_done && !dWEN) ? ramload : '0;
    gnt   = RST ? 2'd0 : state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into a
// scoreboard; a negedge monitor pops and compares whenever a wait output drops.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramren, ramwen;
  logic [1:0]  gnt;

  localparam logic [1:0] Free = 2'd0, Busy = 2'd1, Access = 2'd2, Error = 2'd3;

  typedef struct packed {
    logic        is_d;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] load;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ordr[6] = '{2, 2, 2, 2, 1, 2};

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (clk),
    .RST      (rst),
    .iREN     (iren),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dren),
    .dWEN     (dwen),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramren),
    .ramWEN   (ramwen),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .gnt      (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, {30'b0, gnt}, 32'd0);
    chk({tag, "_ramREN"}, {31'b0, ramren}, 32'd0);
    chk({tag, "_ramWEN"}, {31'b0, ramwen}, 32'd0);
    chk({tag, "_ramaddr"}, ramaddr, 32'd0);
    chk({tag, "_ramstore"}, ramstore, 32'd0);
    chk({tag, "_iwait"}, {31'b0, iwait}, 32'd1);
    chk({tag, "_dwait"}, {31'b0, dwait}, 32'd1);
    chk({tag, "_iload"}, iload, 32'd0);
    chk({tag, "_dload"}, dload, 32'd0);
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task peek;
    #3;
  endtask

  // Monitor: every completion pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!iwait || !dwait) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {30'b0, ~iwait, ~dwait}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_side", {31'b0, ~dwait}, {31'b0, mon_e.is_d});
        chk("done_load", mon_e.is_d ? dload : iload, mon_e.load);
        chk("done_addr", ramaddr, mon_e.addr);
        chk("done_wen", {31'b0, ramwen}, {31'b0, mon_e.wen});
        chk("done_other_wait", {31'b0, mon_e.is_d ? iwait : dwait}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; iren = 1'b1; dren = 1'b0; dwen = 1'b1;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = Free;

    // Reset: idle outputs while asserted and on the cycle after
    tick; peek; chk_idle("rst_init");
    tick; rst = 1'b0; iren = 1'b0; dwen = 1'b0; peek; chk_idle("post_rst");

    // Instruction read, ACCESS in cycle 3
    tick; iren = 1'b1; iaddr = 32'h40; ramstate = Busy; dstore = 32'hFFFF_FFFF;
    peek; chk("ird_c0_gnt", {30'b0, gnt}, 32'd0); chk("ird_c0_ren", {31'b0, ramren}, 32'd0);
    tick; peek;
    chk("ird_c1_gnt", {30'b0, gnt}, 32'd1); chk("ird_c1_ren", {31'b0, ramren}, 32'd1);
    chk("ird_c1_addr", ramaddr, 32'h40); chk("ird_c1_store", ramstore, 32'd0);
    chk("ird_c1_iwait", {31'b0, iwait}, 32'd1);
    tick; peek; chk("ird_c2_gnt", {30'b0, gnt}, 32'd1);
    tick; ramstate = Access; ramload = 32'h8C22_0004;
    sb_q.push_back('{is_d: 1'b0, wen: 1'b0, addr: 32'h40, load: 32'h8C22_0004});
    peek; chk("ird_c3_gnt", {30'b0, gnt}, 32'd1);
    tick; iren = 1'b0; ramstate = Free; peek;
    chk("ird_c4_gnt", {30'b0, gnt}, 32'd0); chk("ird_c4_iload", iload, 32'd0);

    // Simultaneous requests: data first, then instruction
    tick; iren = 1'b1; iaddr = 32'h44; dren = 1'b1; daddr = 32'h100;
    ramstate = Access; ramload = 32'h1111_1111;
    sb_q.push_back('{is_d: 1'b1, wen: 1'b0, addr: 32'h100, load: 32'h1111_1111});
    peek; chk("sim_c0_gnt", {30'b0, gnt}, 32'd0);
    tick; peek; chk("sim_c1_gnt", {30'b0, gnt}, 32'd2); chk("sim_c1_ren", {31'b0, ramren}, 32'd1);
    tick; dren = 1'b0; ramload = 32'h2222_2222;
    sb_q.push_back('{is_d: 1'b0, wen: 1'b0, addr: 32'h44, load: 32'h2222_2222});
    peek; chk("sim_c2_gnt", {30'b0, gnt}, 32'd0); chk("sim_c2_dwait", {31'b0, dwait}, 32'd1);
    tick; peek; chk("sim_c3_gnt", {30'b0, gnt}, 32'd1);
    tick; iren = 1'b0; peek; chk("sim_c4_gnt", {30'b0, gnt}, 32'd0);

    // Starvation: iREN held, back-to-back writes -> D,D,D,D,I,D
    tick; iren = 1'b1; iaddr = 32'h80; dwen = 1'b1; daddr = 32'h200; ramstate = Access;
    for (int k = 0; k < 6; k++) begin
      dstore  = 32'hD000 + k;
      ramload = 32'h5000 + k;
      if (ordr[k] == 2) sb_q.push_back('{is_d: 1'b1, wen: 1'b1, addr: 32'h200, load: 32'h0});
      else sb_q.push_back('{is_d: 1'b0, wen: 1'b0, addr: 32'h80, load: 32'h5000 + k});
      peek; chk("starve_idle_gnt", {30'b0, gnt}, 32'd0);
      tick; peek; chk($sformatf("starve_gnt%0d", k), {30'b0, gnt}, ordr[k]);
      if (ordr[k] == 2) chk("starve_store", ramstore, 32'hD000 + k);
      tick;
    end
    iren = 1'b0; dwen = 1'b0; ramstate = Free;
    peek; chk("starve_end_gnt", {30'b0, gnt}, 32'd0);

    // Write retried through ERROR, then ACCESS
    tick; dwen = 1'b1; daddr = 32'h300; dstore = 32'hCAFE_F00D; ramstate = Error; peek;
    for (int j = 0; j < 3; j++) begin
      tick; peek;
      chk("retry_wen", {31'b0, ramwen}, 32'd1);
      chk("retry_dwait", {31'b0, dwait}, 32'd1);
      chk("retry_gnt", {30'b0, gnt}, 32'd2);
    end
    tick; ramstate = Access;
    sb_q.push_back('{is_d: 1'b1, wen: 1'b1, addr: 32'h300, load: 32'h0});
    peek; chk("retry_acc_wen", {31'b0, ramwen}, 32'd1);
    tick; dwen = 1'b0; ramstate = Free; peek;
    chk("retry_end_gnt", {30'b0, gnt}, 32'd0); chk("retry_end_dwait", {31'b0, dwait}, 32'd1);

    // Abort: dREN dropped in the second DGNT cycle
    tick; dren = 1'b1; daddr = 32'h400; ramstate = Busy; peek;
    tick; peek; chk("abort_c1_gnt", {30'b0, gnt}, 32'd2); chk("abort_c1_ren", {31'b0, ramren}, 32'd1);
    tick; dren = 1'b0; ramstate = Access; peek;
    chk("abort_c2_ren", {31'b0, ramren}, 32'd0); chk("abort_c2_wen", {31'b0, ramwen}, 32'd0);
    chk("abort_c2_dwait", {31'b0, dwait}, 32'd1);
    tick; ramstate = Free; peek; chk("abort_c3_gnt", {30'b0, gnt}, 32'd0);

    // Reset in the middle of an instruction grant
    tick; iren = 1'b1; iaddr = 32'h500; ramstate = Busy; peek;
    tick; peek; chk("rstmid_gnt", {30'b0, gnt}, 32'd1);
    tick; rst = 1'b1; ramstate = Access; ramload = 32'hDEAD_BEEF; peek; chk_idle("rstmid_high");
    tick; rst = 1'b0; iren = 1'b0; peek; chk_idle("rstmid_after");
    tick; peek;

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
